ccg_resp_misr: RTL
==================

# ccg_resp_misr

Sequential response compactor downstream of the 4-input/4-output CCGRCG benchmark logic. It accepts one 4-bit response word `{f4,f3,f2,f1}` per valid/ready handshake and folds it into a multiple-input signature register (MISR). After a programmed number of vectors it compares the signature against an expected value and reports pass/fail. It closes the stimulus → DUT → compaction loop used for dataset self-checks.

## Interface
- `SIG_W`, 16: signature width; legal range 8–32.
- `POLY`, 16'h1021: feedback polynomial taps; low `SIG_W` bits used.
- `SEED`, 16'h0000: signature value loaded on reset and on `start`.
- `VEC_CNT`, 16: number of responses to compact per run; legal range 1–65535.
- `EXP_SIG`, 16'h0000: golden signature for the final compare.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `f1`,`f2`,`f3`,`f4`  in  1 each  response bits from the upstream combinational stage.
- `in_valid`  in  1  response bits valid this cycle.
- `in_ready`  out  1  block accepts a response this cycle.
- `sig`  out  SIG_W  current signature.
- `vec_idx`  out  16  number of responses accepted in the current run.
- `busy`  out  1  high in RUN or CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`; 1 iff `sig == EXP_SIG`.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE → RUN on `start`: `sig` ← SEED, `vec_idx` ← 0.
- RUN: `in_ready` = 1. Each cycle with `in_valid & in_ready`:
  - let `r = {f4,f3,f2,f1}` zero-extended to SIG_W;
  - `sig` ← `({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ r`;
  - `vec_idx` ← `vec_idx + 1`.
- RUN → CHECK on the accept that makes `vec_idx == VEC_CNT`.
- CHECK (1 cycle): `pass` ← `(sig == EXP_SIG)`. Then → DONE.
- DONE: `done` = 1; `sig`, `vec_idx` and `pass` hold. `start` → RUN, with reload as from IDLE.
- `start` during RUN or CHECK is ignored.
- `in_valid` outside RUN is ignored. `in_ready` = 0 there; no state changes.
- `rst_n` = 0 on any edge, including mid-run, aborts the run and forces IDLE regardless of other inputs.

## Timing
- Reset values: `sig` = SEED, `vec_idx` = 0, `in_ready` = 0, `busy` = 0, `done` = 0, `pass` = 0.
- `start` sampled at edge N → `in_ready`/`busy` = 1 from cycle N+1.
- Accepted response updates `sig` and `vec_idx` one cycle after the accepting edge.
- Last accept at edge N: `in_ready` = 0 from N+1 (CHECK), `done` and `pass` valid from N+2.
- Minimum run length: VEC_CNT + 2 cycles after `start`.
- `in_ready` is registered and does not depend combinationally on `in_valid`.

## Configuration
- `CCG_RESP_FIRSTFAIL_EN` defined:
  - adds input `exp_f` [3:0] (per-vector golden response, sampled with `in_valid`);
  - adds outputs `mismatch` (1) and `first_fail_idx` (16);
  - on the first accepted response in a run where `{f4,f3,f2,f1} != exp_f`: `mismatch` ← 1 (sticky) and `first_fail_idx` ← `vec_idx` before increment;
  - both outputs clear on reset and on `start`;
  - `pass` becomes `(sig == EXP_SIG) & ~mismatch`.
- Undefined: these ports and registers do not exist; `pass` depends on the signature only.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `in_valid` = 1 → `sig` = 0x0000, `vec_idx` = 0, `in_ready`/`busy`/`done`/`pass` = 0.
- VEC_CNT = 1, EXP_SIG = 0x0007: `start`, then one response `{f4..f1}` = 4'b0111 (DUT input 0000) → `sig` = 0x0007, `vec_idx` = 1, `done` two cycles later, `pass` = 1.
- VEC_CNT = 2, EXP_SIG = 0x0009: two accepts of 4'b0111, with a 3-cycle `in_valid` = 0 gap between them → `sig` = 0x0009, `pass` = 1; `vec_idx` unchanged during the gap.
- Same run with EXP_SIG = 0x0008 → `done` = 1, `pass` = 0; a `start` pulse mid-run is ignored.
- Feedback: SEED = 0x8000, VEC_CNT = 1, response 4'b0000 → `sig` = 0x1021.
- Mid-run `rst_n` pulse after 5 accepts → IDLE, `vec_idx` = 0. With `CCG_RESP_FIRSTFAIL_EN`, `exp_f` differs at vector 3 → `mismatch` = 1, `first_fail_idx` = 3, `pass` = 0.

Source files
------------

// File: rtl/ccg_resp_misr_if.sv
// Response handshake bundle between the upstream CCGRCG logic and the
// signature compactor. When CCG_RESP_FIRSTFAIL_EN is defined the bundle
// also carries the per-vector golden response exp_f.
interface ccg_resp_misr_if;
   logic       f1;
   logic       f2;
   logic       f3;
   logic       f4;
   logic       in_valid;
   logic       in_ready;
`ifdef CCG_RESP_FIRSTFAIL_EN
   logic [3:0] exp_f;

   modport master (output f1, f2, f3, f4, in_valid, exp_f, input in_ready);
   modport slave  (input f1, f2, f3, f4, in_valid, exp_f, output in_ready);
`else
   modport master (output f1, f2, f3, f4, in_valid, input in_ready);
   modport slave  (input f1, f2, f3, f4, in_valid, output in_ready);
`endif
endinterface

// File: rtl/ccg_resp_misr.sv
// Multiple-input signature register that compacts 4-bit CCGRCG responses.
// A run starts on 'start', folds VEC_CNT accepted responses into 'sig',
// then spends one CHECK cycle comparing against EXP_SIG before parking
// in DONE with the verdict on 'pass'.
// Optional feature macro: CCG_RESP_FIRSTFAIL_EN adds per-vector golden
// compare with a sticky 'mismatch' flag and 'first_fail_idx'.
module ccg_resp_misr #(
   parameter int unsigned      SIG_W   = 16,
   parameter logic [SIG_W-1:0] POLY    = SIG_W'(16'h1021),
   parameter logic [SIG_W-1:0] SEED    = SIG_W'(16'h0000),
   parameter int unsigned      VEC_CNT = 16,
   parameter logic [SIG_W-1:0] EXP_SIG = SIG_W'(16'h0000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   ccg_resp_misr_if.slave   rsp,
   output logic [SIG_W-1:0] sig,
   output logic [15:0]      vec_idx,
   output logic             busy,
   output logic             done,
   output logic             pass
`ifdef CCG_RESP_FIRSTFAIL_EN
   ,
   output logic             mismatch,
   output logic [15:0]      first_fail_idx
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

   // Index of the response whose acceptance completes the run.
   localparam logic [15:0] LAST_IDX = 16'(VEC_CNT - 1);

   state_t           state_q;
   state_t           state_d;
   logic             in_ready_q;
   logic             load;
   logic             accept;
   logic [3:0]       resp;
   logic [SIG_W-1:0] sig_next;

   assign resp         = {rsp.f4, rsp.f3, rsp.f2, rsp.f1};
   assign accept       = rsp.in_valid & in_ready_q;
   assign rsp.in_ready = in_ready_q;
   assign busy         = (state_q == RUN) || (state_q == CHECK);
   assign done         = (state_q == DONE);

   // Next-state decode; 'load' marks the cycle a new run is seeded.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (accept && (vec_idx == LAST_IDX)) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shift with polynomial feedback, then fold in the zero-extended response.
   always_comb begin
      sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-4){1'b0}}, resp};
   end

   // State register; reset aborts any run in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Ready is registered from the next state so it never depends on in_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (state_d == RUN);
      end
   end

   // Signature and vector counter: reseed on start, advance on each accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig     <= SEED;
         vec_idx <= 16'd0;
      end else if (load) begin
         sig     <= SEED;
         vec_idx <= 16'd0;
      end else if (accept) begin
         sig     <= sig_next;
         vec_idx <= vec_idx + 16'd1;
      end
   end

`ifdef CCG_RESP_FIRSTFAIL_EN
   // Latch the index of the first response that disagrees with exp_f.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mismatch       <= 1'b0;
         first_fail_idx <= 16'd0;
      end else if (load) begin
         mismatch       <= 1'b0;
         first_fail_idx <= 16'd0;
      end else if (accept && !mismatch && (resp != rsp.exp_f)) begin
         mismatch       <= 1'b1;
         first_fail_idx <= vec_idx;
      end
   end
`endif

   // Verdict is computed once in CHECK and held through DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass <= 1'b0;
      end else if (load) begin
         pass <= 1'b0;
      end else if (state_q == CHECK) begin
`ifdef CCG_RESP_FIRSTFAIL_EN
         pass <= (sig == EXP_SIG) & ~mismatch;
`else
         pass <= (sig == EXP_SIG);
`endif
      end
   end

endmodule
